// File: rtl/auth_pkg.sv
// Shared definitions for the authentication tag verifier: tag width,
// verdict codes and the verifier state encoding.
package auth_pkg;

    localparam int TAG_W = 40;

    localparam logic [1:0] RES_PASS    = 2'b01;
    localparam logic [1:0] RES_FAIL    = 2'b10;
    localparam logic [1:0] RES_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_HAVE_TAG = 2'd1,
        S_HAVE_REF = 2'd2,
        S_RESULT   = 2'd3
    } state_t;

endpackage

// File: rtl/auth_sat_counter.sv
// Saturating statistics counter with a synchronous clear that takes
// priority over a coincident increment.
module auth_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    // Count up on inc, stick at all-ones, clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/auth_tag_verifier.sv
// Pairs a computed tag with a received reference tag, emits one
// pass/fail/timeout verdict per pair and keeps saturating statistics.
// At most one unmatched tag is held; it is discarded if its partner does
// not arrive within TIMEOUT_CYCLES cycles (0 disables the timeout).
module auth_tag_verifier
    import auth_pkg::state_t, auth_pkg::S_IDLE, auth_pkg::S_HAVE_TAG,
           auth_pkg::S_HAVE_REF, auth_pkg::S_RESULT, auth_pkg::RES_PASS,
           auth_pkg::RES_FAIL, auth_pkg::RES_TIMEOUT;
#(
    parameter int TAG_W          = auth_pkg::TAG_W,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [TAG_W-1:0] tag_tdata,
    input  logic             tag_tvalid,
    output logic             tag_tready,
    input  logic [TAG_W-1:0] ref_tdata,
    input  logic             ref_tvalid,
    output logic             ref_tready,
    output logic [1:0]       result_tdata,
    output logic [TAG_W-1:0] result_diff,
    output logic             result_tvalid,
    input  logic             result_tready,
    input  logic             clear_cnt,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] timeout_cnt
);

    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit TMR_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TMR_W-1:0] TMR_LAST =
        TMR_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    state_t             state, state_next;
    logic [TAG_W-1:0]   tag_hold, tag_hold_next;
    logic [TAG_W-1:0]   ref_hold, ref_hold_next;
    logic [TMR_W-1:0]   timer, timer_next;
    logic [1:0]         code_next;
    logic [TAG_W-1:0]   diff_next;

    logic               tag_hs, ref_hs, res_hs, expire;
    logic [TAG_W-1:0]   cmp_tag, cmp_ref, cmp_diff;
    logic [1:0]         cmp_code;

    // Readies and valid are pure decodes of the state register, so they
    // never depend combinationally on the opposite side's valid.
    assign tag_tready    = (state == S_IDLE) || (state == S_HAVE_REF);
    assign ref_tready    = (state == S_IDLE) || (state == S_HAVE_TAG);
    assign result_tvalid = (state == S_RESULT);

    assign tag_hs = tag_tvalid && tag_tready;
    assign ref_hs = ref_tvalid && ref_tready;
    assign res_hs = result_tvalid && result_tready;
    assign expire = TMR_EN && (timer == TMR_LAST);

    // The held side (if any) is compared against the live side.
    assign cmp_tag  = (state == S_HAVE_TAG) ? tag_hold : tag_tdata;
    assign cmp_ref  = (state == S_HAVE_REF) ? ref_hold : ref_tdata;
    assign cmp_diff = cmp_tag ^ cmp_ref;
    assign cmp_code = (cmp_diff == '0) ? RES_PASS : RES_FAIL;

    // Register state, holding registers, wait timer and the verdict.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    // NOTE: holding registers are reset so a tag dropped by reset can never
    // resurface in a later comparison.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            tag_hold     <= '0;
            ref_hold     <= '0;
            timer        <= '0;
            result_tdata <= 2'b00;
            result_diff  <= '0;
        end else begin
            state        <= state_next;
            tag_hold     <= tag_hold_next;
            ref_hold     <= ref_hold_next;
            timer        <= timer_next;
            result_tdata <= code_next;
            result_diff  <= diff_next;
        end
    end

    // Next-state: pair tags, hold a lone tag, expire it, or drain the verdict.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the case can leave one unassigned and infer a latch.
        state_next    = state;
        tag_hold_next = tag_hold;
        ref_hold_next = ref_hold;
        timer_next    = timer;
        code_next     = result_tdata;
        diff_next     = result_diff;

        unique case (state)
            S_IDLE: begin
                if (tag_hs && ref_hs) begin
                    code_next  = cmp_code;
                    diff_next  = cmp_diff;
                    state_next = S_RESULT;
                end else if (tag_hs) begin
                    tag_hold_next = tag_tdata;
                    timer_next    = '0;
                    state_next    = S_HAVE_TAG;
                end else if (ref_hs) begin
                    ref_hold_next = ref_tdata;
                    timer_next    = '0;
                    state_next    = S_HAVE_REF;
                end
            end
            S_HAVE_TAG, S_HAVE_REF: begin
                // A partner arriving in the expiry cycle still gets compared.
                if ((state == S_HAVE_TAG) ? ref_hs : tag_hs) begin
                    code_next  = cmp_code;
                    diff_next  = cmp_diff;
                    state_next = S_RESULT;
                end else if (expire) begin
                    code_next     = RES_TIMEOUT;
                    diff_next     = '0;
                    tag_hold_next = '0;
                    ref_hold_next = '0;
                    state_next    = S_RESULT;
                end else begin
                    timer_next = timer + TMR_W'(1);
                end
            end
            S_RESULT: begin
                if (res_hs) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    auth_sat_counter #(.CNT_W(CNT_W)) u_pass_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (res_hs && (result_tdata == RES_PASS)),
        .clr   (clear_cnt),
        .count (pass_cnt)
    );

    auth_sat_counter #(.CNT_W(CNT_W)) u_fail_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (res_hs && (result_tdata == RES_FAIL)),
        .clr   (clear_cnt),
        .count (fail_cnt)
    );

    auth_sat_counter #(.CNT_W(CNT_W)) u_timeout_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (res_hs && (result_tdata == RES_TIMEOUT)),
        .clr   (clear_cnt),
        .count (timeout_cnt)
    );

endmodule

// File: tb/tb_auth_tag_verifier.sv
// Scoreboard bench for auth_tag_verifier: stimulus pushes hand-computed
// verdicts, a negedge monitor pops and compares on each result handshake.
module tb_auth_tag_verifier;

    localparam int TW = 40;
    localparam int CW = 2;

    typedef struct packed {
        logic [1:0]    code;
        logic [TW-1:0] diff;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic [TW-1:0] tag_tdata;
    logic          tag_tvalid;
    logic          tag_tready;
    logic [TW-1:0] ref_tdata;
    logic          ref_tvalid;
    logic          ref_tready;
    logic [1:0]    result_tdata;
    logic [TW-1:0] result_diff;
    logic          result_tvalid;
    logic          result_tready;
    logic          clear_cnt;
    logic [CW-1:0] pass_cnt;
    logic [CW-1:0] fail_cnt;
    logic [CW-1:0] timeout_cnt;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t sb_e;
    int   k_wait;
    int   ok_cycles;

    auth_tag_verifier #(
        .TAG_W          (TW),
        .CNT_W          (CW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tag_tdata     (tag_tdata),
        .tag_tvalid    (tag_tvalid),
        .tag_tready    (tag_tready),
        .ref_tdata     (ref_tdata),
        .ref_tvalid    (ref_tvalid),
        .ref_tready    (ref_tready),
        .result_tdata  (result_tdata),
        .result_diff   (result_diff),
        .result_tvalid (result_tvalid),
        .result_tready (result_tready),
        .clear_cnt     (clear_cnt),
        .pass_cnt      (pass_cnt),
        .fail_cnt      (fail_cnt),
        .timeout_cnt   (timeout_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present both tags in one cycle, expect the verdict next cycle, then drain.
    task automatic do_pair(input logic [TW-1:0] t, input logic [TW-1:0] r,
                           input logic [1:0] code, input logic [TW-1:0] diff);
        tag_tdata  = t;
        ref_tdata  = r;
        tag_tvalid = 1'b1;
        ref_tvalid = 1'b1;
        exp_q.push_back(exp_t'{code, diff});
        tick();
        tag_tvalid = 1'b0;
        ref_tvalid = 1'b0;
        check("pair_latency", result_tvalid, 1'b1);
        tick();
    endtask

    // Monitor: compare every result handshake against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && result_tvalid && result_tready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got code %b diff %h expected no verdict",
                             result_tdata, result_diff);
                end else begin
                    sb_e = exp_q.pop_front();
                    check("sb_code", result_tdata, sb_e.code);
                    check("sb_diff", result_diff, sb_e.diff);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        tag_tdata     = '0;
        tag_tvalid    = 1'b0;
        ref_tdata     = '0;
        ref_tvalid    = 1'b0;
        result_tready = 1'b1;
        clear_cnt     = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_readies", {tag_tready, ref_tready}, 2'b11);
        check("rst_valid", result_tvalid, 1'b0);
        check("rst_tdata", result_tdata, 2'b00);
        check("rst_diff", result_diff, 40'h0);
        check("rst_counters", {pass_cnt, fail_cnt, timeout_cnt}, 6'b0);
        rst_n = 1'b1;
        tick();

        // Same-cycle match
        tag_tdata  = 40'h12_3456_789A;
        ref_tdata  = 40'h12_3456_789A;
        tag_tvalid = 1'b1;
        ref_tvalid = 1'b1;
        exp_q.push_back(exp_t'{auth_pkg::RES_PASS, 40'h0});
        tick();
        tag_tvalid = 1'b0;
        ref_tvalid = 1'b0;
        check("t1_latency", result_tvalid, 1'b1);
        check("t1_readies_in_result", {tag_tready, ref_tready}, 2'b00);
        tick();
        check("t1_pass_cnt", pass_cnt, 2'd1);
        check("t1_back_idle", result_tvalid, 1'b0);

        // Split arrival with mismatch, ref five cycles after tag
        tag_tdata  = 40'hFF_0000_0000;
        tag_tvalid = 1'b1;
        tick();
        tag_tvalid = 1'b0;
        ok_cycles  = 0;
        repeat (4) begin
            if (!tag_tready && ref_tready && !result_tvalid) ok_cycles++;
            tick();
        end
        check("t2_hold_readies", ok_cycles, 4);
        ref_tdata  = 40'hFF_0000_0001;
        ref_tvalid = 1'b1;
        exp_q.push_back(exp_t'{auth_pkg::RES_FAIL, 40'h00_0000_0001});
        tick();
        ref_tvalid = 1'b0;
        check("t2_latency", result_tvalid, 1'b1);
        tick();
        check("t2_fail_cnt", fail_cnt, 2'd1);

        // Timeout: ref alone, verdict 8 edges after its handshake
        ref_tdata  = 40'hAB_CDEF_0123;
        ref_tvalid = 1'b1;
        exp_q.push_back(exp_t'{auth_pkg::RES_TIMEOUT, 40'h0});
        tick();
        ref_tvalid = 1'b0;
        k_wait     = 0;
        while (!result_tvalid && k_wait < 16) begin
            tick();
            k_wait++;
        end
        check("t3_timeout_latency", k_wait, 8);
        tick();
        check("t3_timeout_cnt", timeout_cnt, 2'd1);

        // Next tag waits alone; partner lands in the expiry cycle
        tag_tdata  = 40'h33_4455_6677;
        tag_tvalid = 1'b1;
        tick();
        tag_tvalid = 1'b0;
        check("t3_tag_held_readies", {tag_tready, ref_tready}, 2'b01);
        repeat (7) tick();
        check("t3_not_expired_yet", result_tvalid, 1'b0);
        ref_tdata  = 40'h33_4455_6677;
        ref_tvalid = 1'b1;
        exp_q.push_back(exp_t'{auth_pkg::RES_PASS, 40'h0});
        tick();
        ref_tvalid = 1'b0;
        check("t3_expiry_pair_valid", result_tvalid, 1'b1);
        tick();
        check("t3_pass_cnt", pass_cnt, 2'd2);
        check("t3_timeout_cnt_unchanged", timeout_cnt, 2'd1);

        // Backpressure for 20 cycles
        result_tready = 1'b0;
        tag_tdata     = 40'hA5_A5A5_A5A5;
        ref_tdata     = 40'h5A_5A5A_5A5A;
        tag_tvalid    = 1'b1;
        ref_tvalid    = 1'b1;
        exp_q.push_back(exp_t'{auth_pkg::RES_FAIL, 40'hFF_FFFF_FFFF});
        tick();
        tag_tvalid = 1'b0;
        ref_tvalid = 1'b0;
        ok_cycles  = 0;
        repeat (20) begin
            if (result_tvalid && result_tdata == auth_pkg::RES_FAIL &&
                result_diff == 40'hFF_FFFF_FFFF && !tag_tready && !ref_tready)
                ok_cycles++;
            tick();
        end
        check("t4_stable_cycles", ok_cycles, 20);
        check("t4_fail_cnt_held", fail_cnt, 2'd1);
        result_tready = 1'b1;
        tick();
        check("t4_fail_cnt_release", fail_cnt, 2'd2);

        // Clear, then saturate the pass counter
        clear_cnt = 1'b1;
        tick();
        clear_cnt = 1'b0;
        check("t5_cleared", {pass_cnt, fail_cnt, timeout_cnt}, 6'b0);
        repeat (5) do_pair(40'h01_0203_0405, 40'h01_0203_0405, auth_pkg::RES_PASS, 40'h0);
        check("t5_pass_saturated", pass_cnt, 2'd3);

        // Clear coincident with a pass handshake
        tag_tdata  = 40'h77_7777_7777;
        ref_tdata  = 40'h77_7777_7777;
        tag_tvalid = 1'b1;
        ref_tvalid = 1'b1;
        exp_q.push_back(exp_t'{auth_pkg::RES_PASS, 40'h0});
        tick();
        tag_tvalid = 1'b0;
        ref_tvalid = 1'b0;
        clear_cnt  = 1'b1;
        tick();
        clear_cnt = 1'b0;
        check("t5_clear_wins", pass_cnt, 2'd0);

        // Reset mid-wait
        do_pair(40'h00_0000_00F0, 40'h00_0000_000F, auth_pkg::RES_FAIL, 40'h00_0000_00FF);
        check("t6_fail_before_reset", fail_cnt, 2'd1);
        tag_tdata  = 40'hDE_ADBE_EF01;
        tag_tvalid = 1'b1;
        tick();
        tag_tvalid = 1'b0;
        check("t6_tag_held", {tag_tready, ref_tready}, 2'b01);
        rst_n = 1'b0;
        #1;
        check("t6_async_valid", result_tvalid, 1'b0);
        check("t6_async_readies", {tag_tready, ref_tready}, 2'b11);
        check("t6_async_counters", fail_cnt, 2'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("t6_readies_after", {tag_tready, ref_tready}, 2'b11);
        repeat (12) tick();
        check("t6_no_spurious", result_tvalid, 1'b0);

        check("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
